opc1_boot_loader: RTL and testbench
===================================

# opc1_boot_loader

Boot sequencer and memory-bus owner for the OPC-1 CPU. After reset, or on request, it holds the CPU in reset and loads a program image from a byte stream into the 2 KB program RAM starting at address 0. It then releases the CPU and passes the CPU's memory bus through to the RAM. It sits between the CPU core, the single-port RAM and a host byte source such as a UART receiver.

## Interface
- `ADDR_W`, 11, RAM/CPU address width.
- `DATA_W`, 8, data width.
- `RST_HOLD`, 4, cycles the CPU reset is held after the last image byte (minimum 1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `boot_req`  in  1  level; sampled only in RUN, where it starts a reload.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  loader accepts a byte.
- `cpu_address`  in  11  CPU address.
- `cpu_rnw`  in  1  CPU read-not-write.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  read data to CPU.
- `cpu_reset_b`  out  1  active-low CPU reset.
- `mem_address`  out  11  RAM address.
- `mem_wdata`  out  8  RAM write data.
- `mem_we`  out  1  RAM write strobe; RAM writes on the `clk` edge.
- `mem_rdata`  in  8  RAM read data.
- `busy`  out  1  high in every state except RUN.
- `boot_err`  out  1  sticky checksum error (see Configuration).

## Operation
- States: HDR0, HDR1, DATA, [CHK], HOLD, RUN.
- `reset` forces the following:
  - state HDR0;
  - byte counter 0, length 0, hold counter 0, checksum 0;
  - `boot_err` 0;
  - `cpu_reset_b` 0, `s_ready` 1, `busy` 1.
- A byte is accepted on a clock edge where `s_valid & s_ready`. `s_ready` = 1 in HDR0, HDR1, DATA and CHK, and 0 in HOLD and RUN.
- HDR0: an accepted byte sets `len[7:0]`; go to HDR1.
- HDR1: an accepted byte sets `len[10:8]` = `s_data[2:0]`, and `s_data[7:3]` are ignored. Clear the byte counter and checksum; go to DATA.
- Image length N = `len` + 1, giving 1..2048 bytes; `len` = 0x7FF loads the whole RAM.
- DATA, combinational in the accept cycle:
  - `mem_we` = 1;
  - `mem_address` = counter;
  - `mem_wdata` = `s_data`.
- DATA, on each accepted byte:
  - the counter increments;
  - the checksum accumulates `s_data`, modulo 256.
- DATA exit: on acceptance of byte N (counter == `len`), go to CHK if present, otherwise HOLD, and load the hold counter with `RST_HOLD`−1. The counter never wraps past 0x7FF.
- HOLD: decrement the hold counter each cycle; at 0 go to RUN.
- RUN:
  - `cpu_reset_b` = 1;
  - `mem_address` = `cpu_address`;
  - `mem_wdata` = `cpu_wdata`;
  - `mem_we` = ~`cpu_rnw`;
  - `cpu_rdata` = `mem_rdata`.
- RUN, `boot_req` = 1: go to HDR0. `cpu_reset_b` falls on that edge. The CPU still owns the bus during the cycle in which `boot_req` is sampled.
- Outside RUN:
  - `cpu_rdata` = 0, and CPU bus inputs are ignored;
  - `mem_we` = 0 except for DATA accepts;
  - `mem_address` = counter and `mem_wdata` = `s_data`.
- `s_valid` with no accept (HOLD, RUN) has no effect, and bytes are never buffered.

## Timing
- Every output except `cpu_reset_b`, `busy` and `s_ready` is combinational from the current state and inputs.
- `cpu_reset_b`, `busy` and `s_ready` are decoded from the state register only, so they are glitch-free relative to `clk`.
- Without checksum: 2 header bytes + N data bytes, then exactly `RST_HOLD` cycles with `busy` = 1 before `cpu_reset_b` = 1.
- At one byte per cycle, the first RUN cycle is cycle 2 + N + `RST_HOLD` after the first accept, counting from 0.
- With checksum: one more byte, so one more cycle.
- Asserting `reset` mid-load aborts immediately. RAM contents already written are kept, and the loader restarts at HDR0.

## Configuration
- `OPC1_BOOT_CHKSUM_EN` defined:
  - CHK state present; its accepted byte c completes the image.
  - If (checksum + c) mod 256 == 0, go to HOLD.
  - Otherwise set `boot_err` = 1 and go to HDR0; the CPU stays in reset.
  - `boot_err` clears only on `reset` or on a later successful CHK.
- Undefined: no CHK state, and `boot_err` is tied to 0.

## Test plan
- Reset, stream 00 00 A5, `RST_HOLD`=4:
  - one `mem_we` pulse, to address 0x000 with data 0xA5;
  - `cpu_reset_b` rises exactly 4 cycles after the A5 accept;
  - `busy` falls with it.
- Stream FF 07 followed by 2048 bytes (i & 0xFF) with random `s_valid` gaps:
  - writes to 0x000..0x7FF, each once and in order;
  - no write occurs in a gap cycle;
  - no write after 0x7FF.
- In RUN, CPU write of 0x3C to 0x123 then read of 0x123:
  - `mem_we`=1 on the write;
  - `cpu_rdata`=0x3C on the read.
- In RUN, assert `boot_req` for 1 cycle:
  - `cpu_reset_b`=0 and `s_ready`=1 on the next cycle;
  - CPU writes issued after that do not reach RAM.
- With `OPC1_BOOT_CHKSUM_EN`, stream 01 00 10 20 D0: RUN reached, `boot_err`=0.
- With `OPC1_BOOT_CHKSUM_EN`, stream 01 00 10 20 D1: `boot_err`=1, state HDR0, `cpu_reset_b`=0.
- Assert `reset` after 3 of 5 data bytes: immediate HDR0 and `cpu_reset_b`=0; a fresh full stream then loads and runs correctly.

Source files
------------

// File: rtl/opc1_boot_loader_if.sv
// opc1_boot_loader_if
//   Bus bundle for the OPC-1 boot loader: host byte stream, CPU memory bus,
//   RAM port and loader status.
//   slave  : loader view (stream/CPU/RAM-read in, RAM drive/status out)
//   master : environment view (CPU core, RAM and host byte source)
// Parameters: ADDR_W (RAM/CPU address width), DATA_W (data width).
interface opc1_boot_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              boot_req;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_rnw;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_reset_b;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              boot_err;

  modport slave (
    input  boot_req, s_data, s_valid, cpu_address, cpu_rnw, cpu_wdata, mem_rdata,
    output s_ready, cpu_rdata, cpu_reset_b, mem_address, mem_wdata, mem_we,
           busy, boot_err
  );

  modport master (
    output boot_req, s_data, s_valid, cpu_address, cpu_rnw, cpu_wdata, mem_rdata,
    input  s_ready, cpu_rdata, cpu_reset_b, mem_address, mem_wdata, mem_we,
           busy, boot_err
  );
endinterface

// File: rtl/opc1_boot_loader.sv
// opc1_boot_loader
//   Boot sequencer and memory-bus owner for the OPC-1 CPU. Holds the CPU in
//   reset while a length-prefixed image (2 header bytes, len+1 data bytes) is
//   streamed into program RAM from address 0, waits RST_HOLD cycles, then
//   releases the CPU and passes its memory bus straight through to the RAM.
//   A boot_req level seen in RUN starts a reload.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : opc1_boot_loader_if.slave (stream, CPU bus, RAM port, busy/boot_err)
// Build option:
//   OPC1_BOOT_CHKSUM_EN : adds a trailing checksum byte (CHK state); a bad
//                         sum sets the sticky boot_err and returns to HDR0.
//                         Without it boot_err is tied low.
// Assumes ADDR_W > 8 (length high bits come from the second header byte).
module opc1_boot_loader #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 4
) (
  input logic              clk,
  input logic              reset,
  opc1_boot_loader_if.slave bus
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef OPC1_BOOT_CHKSUM_EN
    S_CHK,
`endif
    S_HOLD,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              cpu_reset_b_q, cpu_reset_b_d;
`ifdef OPC1_BOOT_CHKSUM_EN
  logic              err_q, err_d;
`endif

  logic              accept;
  logic [DATA_W-1:0] sum_next;

  assign accept   = bus.s_valid & s_ready_q;
  assign sum_next = sum_q + bus.s_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hold_d  = hold_q;
    sum_d   = sum_q;
`ifdef OPC1_BOOT_CHKSUM_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_HDR0: if (accept) begin
        len_d[7:0] = bus.s_data[7:0];
        state_d    = S_HDR1;
      end
      S_HDR1: if (accept) begin
        len_d[ADDR_W-1:8] = bus.s_data[ADDR_W-9:0];
        cnt_d             = '0;
        sum_d             = '0;
        state_d           = S_DATA;
      end
      S_DATA: if (accept) begin
        sum_d = sum_next;
        if (cnt_q == len_q) begin
`ifdef OPC1_BOOT_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
`endif
        end else begin
          // Counter stops on the last byte so a full 2 KB image cannot wrap.
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef OPC1_BOOT_CHKSUM_EN
      S_CHK: if (accept) begin
        if (sum_next == '0) begin
          err_d   = 1'b0;
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_HDR0;
        end
      end
`endif
      S_HOLD: begin
        if (hold_q == '0) state_d = S_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      S_RUN: if (bus.boot_req) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase

    // Status outputs are registered from the next state so they change only
    // on clk and always agree with state_q.
    s_ready_d     = (state_d != S_HOLD) && (state_d != S_RUN);
    busy_d        = (state_d != S_RUN);
    cpu_reset_b_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HDR0;
      cnt_q         <= '0;
      len_q         <= '0;
      hold_q        <= '0;
      sum_q         <= '0;
      s_ready_q     <= 1'b1;
      busy_q        <= 1'b1;
      cpu_reset_b_q <= 1'b0;
`ifdef OPC1_BOOT_CHKSUM_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      hold_q        <= hold_d;
      sum_q         <= sum_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      cpu_reset_b_q <= cpu_reset_b_d;
`ifdef OPC1_BOOT_CHKSUM_EN
      err_q         <= err_d;
`endif
    end
  end

  // RAM port mux: CPU owns the bus in RUN, the loader everywhere else.
  always_comb begin
    if (state_q == S_RUN) begin
      bus.mem_address = bus.cpu_address;
      bus.mem_wdata   = bus.cpu_wdata;
      bus.mem_we      = ~bus.cpu_rnw;
      bus.cpu_rdata   = bus.mem_rdata;
    end else begin
      bus.mem_address = cnt_q;
      bus.mem_wdata   = bus.s_data;
      bus.mem_we      = (state_q == S_DATA) && accept;
      bus.cpu_rdata   = '0;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.busy        = busy_q;
  assign bus.cpu_reset_b = cpu_reset_b_q;
`ifdef OPC1_BOOT_CHKSUM_EN
  assign bus.boot_err    = err_q;
`else
  assign bus.boot_err    = 1'b0;
`endif

endmodule

// File: tb/tb_opc1_boot_loader.sv
// tb_opc1_boot_loader
//   Self-checking bench for opc1_boot_loader: behavioural RAM, reference
//   memory image, write-sequence monitor, table-driven RUN bus vectors and
//   hand-written reload / reset-abort / checksum sequences.
module tb_opc1_boot_loader;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 2048;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;
  typedef struct {
    logic [10:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic        exp_we;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  opc1_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  opc1_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-port RAM: write on clk edge, asynchronous read.
  logic [7:0] ram [DEPTH];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_address];

  logic [7:0] model [DEPTH];   // expected RAM contents
  wr_t        wq[$];           // loader writes seen while busy

  int checks = 0;
  int errors = 0;

  always @(negedge clk)
    if (bus.mem_we && bus.busy) wq.push_back(wr_t'{bus.mem_address, bus.mem_wdata});

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.boot_req    = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_data      = 8'h00;
    bus.cpu_rnw     = 1'b1;
    bus.cpu_address = '0;
    bus.cpu_wdata   = 8'h00;
  endtask

  // Feeds bytes with random s_valid gaps; CPU inputs are scrambled meanwhile
  // to show they are ignored outside RUN. Returns at posedge+1 after the
  // last accept.
  task automatic send_stream(input byte_q_t s, input int gap_pct);
    int i = 0;
    int guard = 0;
    while (i < s.size()) begin
      bus.s_data      = s[i];
      bus.s_valid     = ($urandom_range(0, 99) >= gap_pct);
      bus.cpu_rnw     = 1'($urandom);
      bus.cpu_address = 11'($urandom);
      bus.cpu_wdata   = 8'($urandom);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) i++;
      @(posedge clk); #1;
      guard++;
      if (guard > s.size() * 10 + 50) begin
        check("stream_timeout", 1, 0);
        break;
      end
    end
    idle();
  endtask

  function automatic byte_q_t make_stream(input byte_q_t data);
    byte_q_t     s;
    int unsigned len;
    logic [7:0]  sum;
    logic [7:0]  c;
    len = data.size() - 1;
    sum = 8'h00;
    s.push_back(len[7:0]);
    s.push_back({5'b0, len[10:8]});
    foreach (data[i]) begin
      s.push_back(data[i]);
      sum = sum + data[i];
    end
    c = 8'h00 - sum;
`ifdef OPC1_BOOT_CHKSUM_EN
    s.push_back(c);
`endif
    return s;
  endfunction

  // Expects exactly RST_HOLD busy cycles after the final accept, then RUN.
  task automatic wait_run(input string tag);
    int k;
    bit hold_ok = 1'b1;
    for (k = 1; k <= RST_HOLD + 20; k++) begin
      @(negedge clk);
      if (bus.cpu_reset_b) break;
      if (!bus.busy || bus.s_ready) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({tag, "_run_latency"}, k, RST_HOLD + 1);
    check({tag, "_hold_busy"}, int'(hold_ok), 1);
    check({tag, "_run_busy"}, int'(bus.busy), 0);
    check({tag, "_run_s_ready"}, int'(bus.s_ready), 0);
    @(posedge clk); #1;
  endtask

  task automatic load_and_check(input byte_q_t data, input int gap_pct, input string tag);
    byte_q_t s;
    int bad = 0;
    s = make_stream(data);
    wq.delete();
    send_stream(s, gap_pct);
    check({tag, "_nwrites"}, wq.size(), data.size());
    foreach (wq[i])
      if (i < data.size())
        if (int'(wq[i].a) != i || wq[i].d != data[i]) bad++;
    check({tag, "_write_seq"}, bad, 0);
    bad = 0;
    foreach (data[i]) begin
      if (ram[i] != data[i]) bad++;
      model[i] = data[i];
    end
    check({tag, "_ram_image"}, bad, 0);
    wait_run(tag);
    check({tag, "_boot_err"}, int'(bus.boot_err), 0);
  endtask

  task automatic reboot();
    bus.boot_req = 1'b1;
    @(posedge clk); #1;
    bus.boot_req = 1'b0;
    @(negedge clk);
    check("reboot_s_ready", int'(bus.s_ready), 1);
    @(posedge clk); #1;
  endtask

  function automatic byte_q_t rand_image(input int n);
    byte_q_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t d;
    byte_q_t s;
    vec_t    tbl[7];
    int      bad;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 8'h00;
      model[i] = 8'h00;
    end
    idle();
    reset           = 1'b1;
    bus.cpu_rnw     = 1'b0;
    bus.cpu_address = 11'h5A5;

    // Reset state
    @(negedge clk);
    check("rst_cpu_reset_b", int'(bus.cpu_reset_b), 0);
    check("rst_s_ready", int'(bus.s_ready), 1);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_boot_err", int'(bus.boot_err), 0);
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_cpu_rdata", int'(bus.cpu_rdata), 0);
    check("rst_mem_address", int'(bus.mem_address), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // Minimal image 00 00 A5
    d = {8'hA5};
    load_and_check(d, 0, "a5");

    // Reload request: CPU still owns the bus in the sampling cycle only
    bus.boot_req    = 1'b1;
    bus.cpu_rnw     = 1'b0;
    bus.cpu_address = 11'h010;
    bus.cpu_wdata   = 8'h77;
    @(negedge clk);
    check("breq_cpu_we", int'(bus.mem_we), 1);
    check("breq_cpu_reset_b", int'(bus.cpu_reset_b), 1);
    model[16] = 8'h77;
    @(posedge clk); #1;
    bus.boot_req  = 1'b0;
    bus.cpu_wdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("breq_after_cpu_reset_b", int'(bus.cpu_reset_b), 0);
      check("breq_after_s_ready", int'(bus.s_ready), 1);
      check("breq_after_mem_we", int'(bus.mem_we), 0);
      check("breq_after_cpu_rdata", int'(bus.cpu_rdata), 0);
      @(posedge clk); #1;
    end
    idle();
    check("breq_ram_kept", int'(ram[16]), int'(model[16]));

    // Full 2 KB image with random gaps
    d = {};
    for (int i = 0; i < DEPTH; i++) d.push_back(8'(i));
    load_and_check(d, 30, "full");

    // RUN pass-through vectors; old contents follow from the i&FF image
    tbl[0] = '{11'h123, 1'b0, 8'h3C, 1'b1, 8'h23};
    tbl[1] = '{11'h123, 1'b1, 8'h00, 1'b0, 8'h3C};
    tbl[2] = '{11'h7FF, 1'b0, 8'h55, 1'b1, 8'hFF};
    tbl[3] = '{11'h7FF, 1'b1, 8'h00, 1'b0, 8'h55};
    tbl[4] = '{11'h000, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[5] = '{11'h000, 1'b0, 8'hAA, 1'b1, 8'h00};
    tbl[6] = '{11'h124, 1'b1, 8'h00, 1'b0, 8'h24};
    foreach (tbl[i]) begin
      bus.cpu_address = tbl[i].addr;
      bus.cpu_rnw     = tbl[i].rnw;
      bus.cpu_wdata   = tbl[i].wdata;
      @(negedge clk);
      check($sformatf("tbl%0d_mem_we", i), int'(bus.mem_we), int'(tbl[i].exp_we));
      check($sformatf("tbl%0d_mem_address", i), int'(bus.mem_address), int'(tbl[i].addr));
      check($sformatf("tbl%0d_cpu_rdata", i), int'(bus.cpu_rdata), int'(tbl[i].exp_rdata));
      if (!tbl[i].rnw) model[tbl[i].addr] = tbl[i].wdata;
      @(posedge clk); #1;
    end

    // Random CPU traffic against the reference memory
    for (int i = 0; i < 150; i++) begin
      bus.cpu_address = 11'($urandom_range(0, 31));
      bus.cpu_rnw     = 1'($urandom);
      bus.cpu_wdata   = 8'($urandom);
      @(negedge clk);
      check("rnd_run_mem_we", int'(bus.mem_we), int'(!bus.cpu_rnw));
      if (bus.cpu_rnw) check("rnd_run_rdata", int'(bus.cpu_rdata), int'(model[bus.cpu_address]));
      else             model[bus.cpu_address] = bus.cpu_wdata;
      @(posedge clk); #1;
    end
    idle();

    // Random images
    for (int r = 0; r < 4; r++) begin
      reboot();
      d = rand_image($urandom_range(1, 64));
      load_and_check(d, $urandom_range(0, 50), $sformatf("rnd%0d", r));
    end
    reboot();

`ifdef OPC1_BOOT_CHKSUM_EN
    s = {8'h01, 8'h00, 8'h10, 8'h20, 8'hD0};
    send_stream(s, 0);
    model[0] = 8'h10;
    model[1] = 8'h20;
    wait_run("chk_ok");
    check("chk_ok_boot_err", int'(bus.boot_err), 0);
    reboot();
    s = {8'h01, 8'h00, 8'h10, 8'h20, 8'hD1};
    send_stream(s, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("chk_bad_boot_err", int'(bus.boot_err), 1);
      check("chk_bad_cpu_reset_b", int'(bus.cpu_reset_b), 0);
      check("chk_bad_s_ready", int'(bus.s_ready), 1);
      @(posedge clk); #1;
    end
    d = rand_image(6);
    load_and_check(d, 20, "chk_clear");
    reboot();
`endif

    // Reset after 3 of 5 data bytes
    d = rand_image(3);
    s = {8'h04, 8'h00, d[0], d[1], d[2]};
    send_stream(s, 0);
    reset = 1'b1;
    #2;
    check("abort_cpu_reset_b", int'(bus.cpu_reset_b), 0);
    check("abort_s_ready", int'(bus.s_ready), 1);
    check("abort_busy", int'(bus.busy), 1);
    check("abort_mem_address", int'(bus.mem_address), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 3; i++) if (ram[i] != d[i]) bad++;
    check("abort_ram_kept", bad, 0);
    d = rand_image(5);
    load_and_check(d, 25, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
